// File: rtl/fp32_to_fp16_conv.sv
// fp32 -> fp16 narrowing converter.
// Two register stages with a valid/ready handshake, round-to-nearest-even,
// and IEEE exception flags. Status flags are sticky across output transfers.
module fp32_to_fp16_conv (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] fp32,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] fp16,
  output logic [3:0]  out_flags,
  input  logic        status_clr,
  output logic [3:0]  status_flags
);

  // Operand class carried from stage 1 to stage 2
  localparam logic [1:0] K_FINAL = 2'd0;  // result fully decided in stage 1
  localparam logic [1:0] K_NORM  = 2'd1;  // normal fp16 result, needs rounding
  localparam logic [1:0] K_SUB   = 2'd2;  // subnormal fp16 result, needs rounding

  // Flag bit positions: {invalid, overflow, underflow, inexact}
  localparam logic [3:0] F_OVF_INX = 4'b0101;
  localparam logic [3:0] F_UNF_INX = 4'b0011;

  // RNE rounding and final packing; returns {fp16, flags}
  function automatic logic [19:0] round_pack(
    input logic [1:0]  kind,
    input logic        sign,
    input logic [14:0] pack,
    input logic [3:0]  pflags,
    input logic [4:0]  exp5,
    input logic [9:0]  mant,
    input logic        g,
    input logic        st
  );
    logic        up;
    logic        inx;
    logic [10:0] sum;
    logic [19:0] res;
    up  = g & (st | mant[0]);
    inx = g | st;
    sum = {1'b0, mant} + {10'b0, up};
    res = {sign, pack, pflags};
    if (kind == K_NORM) begin
      if (sum[10]) begin
        if (exp5 == 5'd30) res = {sign, 15'h7C00, F_OVF_INX};
        else               res = {sign, exp5 + 5'd1, 10'b0, 3'b000, inx};
      end else begin
        res = {sign, exp5, sum[9:0], 3'b000, inx};
      end
    end else if (kind == K_SUB) begin
      // A carry into bit 10 lands exactly on the min-normal encoding 0x0400
      res = {sign, 4'b0, sum, 2'b00, inx, inx};
    end
    return res;
  endfunction

  logic        en1;
  logic        en2;

  logic        vld_p1_q;
  logic [1:0]  kind_p1_q;
  logic        sign_p1_q;
  logic [14:0] pack_p1_q;
  logic [3:0]  pflags_p1_q;
  logic [4:0]  exp_p1_q;
  logic [9:0]  mant_p1_q;
  logic        guard_p1_q;
  logic        sticky_p1_q;

  logic [1:0]  kind_d;
  logic [14:0] pack_d;
  logic [3:0]  pflags_d;
  logic [4:0]  exp_d;
  logic [33:0] aligned;
  logic [3:0]  sh_sub;

  logic        out_valid_q;
  logic [15:0] fp16_q;
  logic [3:0]  flags_q;
  logic [3:0]  status_q;
  logic [19:0] rounded;

  assign en2      = !out_valid_q | out_ready;
  assign en1      = !vld_p1_q | en2;
  assign in_ready = en1;

  // Decode, classify and align the mantissa for stage 1
  always_comb begin
    kind_d   = K_FINAL;
    pack_d   = 15'b0;
    pflags_d = 4'b0;
    exp_d    = 5'(fp32[30:23] - 8'd112);
    sh_sub   = 4'(8'd112 - fp32[30:23]);
    // Normal: mant/guard/sticky sit at [33:24]/[23]/[22:0] with no shift.
    aligned  = {fp32[22:0], 11'b0};
    if (fp32[30:23] == 8'd255) begin
      if (fp32[22:0] != 23'b0) begin
        pack_d   = {5'h1F, 1'b1, fp32[21:13]};
        pflags_d = {~fp32[22], 3'b000};
      end else begin
        pack_d   = 15'h7C00;
      end
    end else if (fp32[30:23] == 8'd0) begin
      if (fp32[22:0] != 23'b0) pflags_d = F_UNF_INX;
    end else if (fp32[30:23] > 8'd142) begin
      pack_d   = 15'h7C00;
      pflags_d = F_OVF_INX;
    end else if (fp32[30:23] >= 8'd113) begin
      kind_d   = K_NORM;
    end else if (fp32[30:23] >= 8'd102) begin
      kind_d   = K_SUB;
      // Hidden bit starts at bit 33; a shift of at most 10 only drops the
      // zero padding, so guard/sticky stay exact.
      aligned  = {1'b1, fp32[22:0], 10'b0} >> sh_sub;
    end else begin
      pflags_d = F_UNF_INX;
    end
  end

  // ---- stage 1: decoded operand ----
  // Stage-1 valid advances whenever stage 1 may be overwritten
  always_ff @(posedge clk) begin
    if (rst)      vld_p1_q <= 1'b0;
    else if (en1) vld_p1_q <= in_valid;
  end

  // Stage-1 datapath captures an accepted operand
  always_ff @(posedge clk) begin
    if (en1 && in_valid) begin
      kind_p1_q   <= kind_d;
      sign_p1_q   <= fp32[31];
      pack_p1_q   <= pack_d;
      pflags_p1_q <= pflags_d;
      exp_p1_q    <= exp_d;
      mant_p1_q   <= aligned[33:24];
      guard_p1_q  <= aligned[23];
      sticky_p1_q <= |aligned[22:0];
    end
  end

  assign rounded = round_pack(kind_p1_q, sign_p1_q, pack_p1_q, pflags_p1_q,
                              exp_p1_q, mant_p1_q, guard_p1_q, sticky_p1_q);

  // ---- stage 2: rounded, packed result ----
  // Output register loads only when empty or being drained
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      fp16_q      <= 16'b0;
      flags_q     <= 4'b0;
    end else if (en2) begin
      out_valid_q <= vld_p1_q;
      if (vld_p1_q) {fp16_q, flags_q} <= rounded;
    end
  end

  // Sticky status accumulates flags of completed transfers
  always_ff @(posedge clk) begin
    if (rst)                          status_q <= 4'b0;
    else if (out_valid_q && out_ready) status_q <= status_clr ? flags_q : (status_q | flags_q);
    else if (status_clr)              status_q <= 4'b0;
  end

  assign out_valid    = out_valid_q;
  assign fp16         = fp16_q;
  assign out_flags    = flags_q;
  assign status_flags = status_q;

endmodule

// File: tb/tb_fp32_to_fp16_conv.sv
// Self-checking bench for fp32_to_fp16_conv: vector table plus scoreboard,
// with hand-written latency, backpressure, status and reset sequences.
module tb_fp32_to_fp16_conv;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] fp32;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] fp16;
  logic [3:0]  out_flags;
  logic        status_clr;
  logic [3:0]  status_flags;

  fp32_to_fp16_conv dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .fp32         (fp32),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .fp16         (fp16),
    .out_flags    (out_flags),
    .status_clr   (status_clr),
    .status_flags (status_flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [15:0] h;
    logic [3:0]  f;
  } vec_t;

  typedef struct {
    logic [15:0] h;
    logic [3:0]  f;
  } exp_t;

  vec_t tbl[$];
  vec_t bp[$];
  exp_t sb[$];

  int   n_vec = 0;
  int   n_fail = 0;
  int   n_acc = 0;
  logic prev_stall = 1'b0;
  logic [15:0] held_h;
  logic [3:0]  held_f;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic add(input logic [31:0] a, input logic [15:0] h, input logic [3:0] f);
    vec_t v;
    v.a = a; v.h = h; v.f = f;
    tbl.push_back(v);
  endtask

  // Drive one operand; the expectation is queued at the accepting edge.
  task automatic send(input logic [31:0] a, input logic [15:0] h, input logic [3:0] f);
    int   t;
    exp_t e;
    t = 0;
    fp32 = a;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_vec++;
      n_fail++;
      $display("FAIL accept_timeout: operand %h never accepted", a);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      e.h = h; e.f = f;
      sb.push_back(e);
      n_acc++;
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 300) begin
      @(posedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // Output monitor: compares transfers against the scoreboard and checks
  // that a stalled result does not change before it is taken.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("stall_hold", {11'b0, out_valid, fp16, out_flags}, {11'b0, 1'b1, held_h, held_f});
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_output: got %h/%b, required no output", fp16, out_flags);
        end else begin
          e = sb.pop_front();
          check("result", {12'b0, fp16, out_flags}, {12'b0, e.h, e.f});
        end
      end
      prev_stall = out_valid && !out_ready;
      held_h = fp16;
      held_f = out_flags;
    end
  end

  initial begin
    logic [3:0] exp_status;
    int t;

    // flags: 8=invalid 4=overflow 2=underflow 1=inexact
    add(32'hC0D00000, 16'hC680, 4'h0);
    add(32'h80000000, 16'h8000, 4'h0);
    add(32'h3F800000, 16'h3C00, 4'h0);
    add(32'h3F801000, 16'h3C00, 4'h1);
    add(32'h3F803000, 16'h3C02, 4'h1);
    add(32'h3F802000, 16'h3C01, 4'h0);
    add(32'h477FE000, 16'h7BFF, 4'h0);
    add(32'h477FF000, 16'h7C00, 4'h5);
    add(32'h7F7FFFFF, 16'h7C00, 4'h5);
    add(32'hC7800000, 16'hFC00, 4'h5);
    add(32'h38800000, 16'h0400, 4'h0);
    add(32'h33800000, 16'h0001, 4'h0);
    add(32'h33000000, 16'h0000, 4'h3);
    add(32'h387FF000, 16'h0400, 4'h3);
    add(32'h387FC000, 16'h03FF, 4'h0);
    add(32'h0D000000, 16'h0000, 4'h3);
    add(32'h00000001, 16'h0000, 4'h3);
    add(32'h7F800000, 16'h7C00, 4'h0);
    add(32'hFF800000, 16'hFC00, 4'h0);
    add(32'h7F800001, 16'h7E00, 4'h8);
    add(32'hFF800001, 16'hFE00, 4'h8);
    add(32'h7FC00000, 16'h7E00, 4'h0);

    rst = 1'b1; in_valid = 1'b0; fp32 = 32'b0; out_ready = 1'b1; status_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_fp16", {16'b0, fp16}, 32'd0);
    check("rst_flags", {28'b0, out_flags}, 32'd0);
    check("rst_status", {28'b0, status_flags}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);

    // Latency: accept in cycle c, out_valid during cycle c+2
    fp32 = 32'h40700000;
    in_valid = 1'b1;
    @(negedge clk);
    check("lat_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    begin
      exp_t e;
      e.h = 16'h4380; e.f = 4'h0;
      sb.push_back(e);
    end
    #1;
    in_valid = 1'b0;
    check("lat_early", {31'b0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    check("lat_valid", {31'b0, out_valid}, 32'd1);
    check("lat_data", {16'b0, fp16}, 32'h4380);
    wait_drain();

    // Table vectors streamed back-to-back
    exp_status = 4'h0;
    foreach (tbl[i]) begin
      send(tbl[i].a, tbl[i].h, tbl[i].f);
      exp_status = exp_status | tbl[i].f;
    end
    wait_drain();
    check("status_accum", {28'b0, status_flags}, {28'b0, exp_status});

    // Backpressure: 5 operands with the output stalled for 4 cycles
    begin
      vec_t v;
      v.a = 32'h3F800000; v.h = 16'h3C00; v.f = 4'h0; bp.push_back(v);
      v.a = 32'hC0D00000; v.h = 16'hC680; v.f = 4'h0; bp.push_back(v);
      v.a = 32'h7FC00000; v.h = 16'h7E00; v.f = 4'h0; bp.push_back(v);
      v.a = 32'h33800000; v.h = 16'h0001; v.f = 4'h0; bp.push_back(v);
      v.a = 32'h477FE000; v.h = 16'h7BFF; v.f = 4'h0; bp.push_back(v);
    end
    out_ready = 1'b0;
    n_acc = 0;
    fork
      begin
        foreach (bp[i]) send(bp[i].a, bp[i].h, bp[i].f);
      end
    join_none
    repeat (4) @(posedge clk);
    #2;
    check("bp_accepts", n_acc, 32'd2);
    check("bp_in_ready", {31'b0, in_ready}, 32'd0);
    out_ready = 1'b1;
    t = 0;
    while (n_acc < 5 && t < 200) begin
      @(posedge clk);
      t++;
    end
    check("bp_all_accepted", n_acc, 32'd5);
    wait_drain();

    // Status clear without a transfer
    status_clr = 1'b1;
    @(posedge clk);
    #1;
    status_clr = 1'b0;
    check("status_clr_idle", {28'b0, status_flags}, 32'd0);
    send(32'h477FF000, 16'h7C00, 4'h5);
    wait_drain();
    check("status_ovf", {28'b0, status_flags}, 32'h5);
    status_clr = 1'b1;
    @(posedge clk);
    #1;
    status_clr = 1'b0;
    check("status_clr_after", {28'b0, status_flags}, 32'd0);

    // Reset with two operands in flight
    out_ready = 1'b0;
    send(32'h40700000, 16'h4380, 4'h0);
    send(32'h477FF000, 16'h7C00, 4'h5);
    check("inflight_valid", {31'b0, out_valid}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst_fp16", {16'b0, fp16}, 32'd0);
    check("mid_rst_flags", {28'b0, out_flags}, 32'd0);
    check("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("no_stale", {31'b0, out_valid}, 32'd0);
    check("no_stale_status", {28'b0, status_flags}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
